// File: rtl/mem_access_stage.sv
// MEM stage of the RISCVX pipeline: drives the ready-handshaked data bus, formats load data,
// stalls during multi-cycle accesses and aborts hung ones. Optional: MEM_MISALIGN_TRAP_EN.
module mem_access_stage #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread_MEM,
    input  logic        memwrite_MEM,
    input  logic [2:0]  funct3_MEM,
    input  logic [31:0] ALU_data_MEM,
    input  logic [31:0] store_data_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic [31:0] mem_data_MEM,
    output logic        mem_stall,
    output logic        mem_error
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t      state;
    logic [7:0]  count;

    logic        access;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misalign;
    logic        req_c;
    logic        stall_c;
    logic        error_c;
    logic        complete;
    logic        abort;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_c;

    always_comb begin
        access  = memread_MEM | memwrite_MEM;
        is_byte = (funct3_MEM[1:0] == 2'b00);
        is_half = (funct3_MEM[1:0] == 2'b01);
        is_word = !is_byte && !is_half;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign = access && ((is_half && ALU_data_MEM[0]) ||
                              (is_word && (ALU_data_MEM[1:0] != 2'b00)));
`else
        misalign = 1'b0;
`endif
    end

    // Handshake outputs are combinational so a zero-wait memory costs no stall cycle.
    always_comb begin
        req_c    = 1'b0;
        stall_c  = 1'b0;
        error_c  = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE: begin
                if (misalign) begin
                    error_c = 1'b1;
                end else if (access) begin
                    req_c = 1'b1;
                    if (dmem_ready) complete = 1'b1;
                    else            stall_c  = 1'b1;
                end
            end
            WAIT: begin
                req_c = 1'b1;
                if (dmem_ready) begin
                    complete = 1'b1;
                end else if (count == TIMEOUT) begin
                    abort   = 1'b1;
                    error_c = 1'b1;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_c && !complete) begin
                        state <= WAIT;
                        count <= 8'd1;
                    end
                end
                WAIT: begin
                    if (complete || abort) begin
                        state <= IDLE;
                        count <= 8'd0;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= 8'd0;
                end
            endcase
        end
    end

    // Store lanes: the byte/halfword is replicated so memory can pick it up at any enabled lane.
    always_comb begin
        if (is_byte) begin
            be_c    = 4'b0001 << ALU_data_MEM[1:0];
            wdata_c = {4{store_data_MEM[7:0]}};
        end else if (is_half) begin
            be_c    = ALU_data_MEM[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{store_data_MEM[15:0]}};
        end else begin
            be_c    = 4'b1111;
            wdata_c = store_data_MEM;
        end
        if (!memwrite_MEM) be_c = 4'b1111;
    end

    always_comb begin
        byte_lane = dmem_rdata[{ALU_data_MEM[1:0], 3'b000} +: 8];
        half_lane = ALU_data_MEM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (is_byte)
            load_c = funct3_MEM[2] ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        else if (is_half)
            load_c = funct3_MEM[2] ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
        else
            load_c = dmem_rdata;
    end

    assign dmem_req     = !reset && req_c;
    assign dmem_we      = !reset && req_c && memwrite_MEM;
    assign dmem_addr    = reset ? 32'd0 : {ALU_data_MEM[31:2], 2'b00};
    assign dmem_be      = reset ? 4'd0  : be_c;
    assign dmem_wdata   = reset ? 32'd0 : wdata_c;
    assign mem_data_MEM = (!reset && complete && !memwrite_MEM) ? load_c : 32'd0;
    assign mem_stall    = !reset && stall_c;
    assign mem_error    = !reset && error_c;

endmodule
